button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end stage that feeds the SoC top-level `buttons_i` input and the memory-mapped button register.
- Raw, asynchronous, bouncing push-button pins enter here.
- Outputs:
  - clean debounced levels;
  - one-cycle press/release pulses;
  - a sticky per-button event register that software clears through a mask.
- One instance per board, placed between the pad ring and the SoC top.

Parameters:
- BTN_NUM, 4, number of buttons handled; one independent channel each.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must differ from the stable level before the stable level flips (10 ms at 100 MHz). Legal range is >=2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the per-channel debounce counter. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. Assertion is asynchronous; release must be synchronous to clk upstream.
- buttons_raw_i  in  BTN_NUM  raw pad inputs, asynchronous to clk, 1 = pressed.
- buttons_o  out  BTN_NUM  debounced stable level per button; drives SoC `buttons_i`.
- press_o  out  BTN_NUM  one-cycle pulse on a debounced 0->1 transition.
- release_o  out  BTN_NUM  one-cycle pulse on a debounced 1->0 transition.
- event_o  out  BTN_NUM  sticky "pressed since last clear" flags.
- event_clr_i  in  BTN_NUM  per-bit clear mask for event_o, sampled every cycle; driven by the memory block on a button-register write.

Behaviour:
- Reset (rst=0, async): both sync flops, stable, cnt, press_o, release_o and event_o all go to 0.
  - Reset mid-debounce discards the partial count.
  - After release, every channel starts from "not pressed".
- Synchronizer: two flops per bit, s1 <= raw, s2 <= s1. Only s2 is used downstream.
- Debounce, per channel, evaluated each rising edge:
  - s2 == stable: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the qualification.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
- Latency: a clean raw step sampled at edge E appears on buttons_o after edge E+1+DEBOUNCE_CYCLES. That is 2 sync edges, with the DEBOUNCE_CYCLES-th differing sample causing the flip.
- Pulses (registered, set at the same edge as the flip):
  - press_o <= 1 when stable flips 0->1; release_o <= 1 when stable flips 1->0; otherwise both <= 0.
  - Each pulse is exactly one cycle wide and coincides with the first cycle buttons_o shows the new level.
  - press_o and release_o are never both high on one bit.
- Sticky events, per bit, each edge: event <= (event & ~event_clr_i) | press_next, where press_next is the value being loaded into press_o.
  - If a clear and a new press occur in the same cycle, the press wins and event stays 1.
  - Clearing a bit that is 0 has no effect.
  - Clear bits for other buttons do not disturb their neighbours.
- A held button produces no repeated pulses. A bounce train that never stays stable for DEBOUNCE_CYCLES produces no pulse.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Decomposition:
- Shared defines file:
  - `BTN_NUM (4);
  - `BTN_DEBOUNCE_CYCLES (1000000);
  - BTN_EVENT_ADDR, the memory-map offset used by the memory block for read and clear.
- Sub-module btn_debounce_bit contains, for one channel: the sync flops, cnt, stable, and the press/release generation. button_conditioner generates BTN_NUM instances of it and holds the event register and clear logic.

Test Plan (DEBOUNCE_CYCLES=4, BTN_NUM=4):
- Reset held low then released -> all outputs 0. Force raw=4'b1111 during reset -> outputs still 0 until 6 edges after release.
- raw[0] 0->1 clean at edge 0 -> buttons_o[0]=1 and press_o=4'b0001 for one cycle after edge 5. event_o[0]=1 from the same edge. Hold 20 cycles -> no further press_o.
- raw[1] bounces 1,0,1,1,0,1,1,1,1 (one value per cycle) -> no change until the final run of 4 ones. buttons_o[1] rises exactly once, with one press_o[1] pulse.
- Glitch: raw[2]=1 for 3 cycles then 0 -> buttons_o[2], press_o[2] and event_o[2] stay 0 throughout.
- event_o=4'b0011, drive event_clr_i=4'b0001 for one cycle -> event_o=4'b0010. Then assert event_clr_i[1] in the cycle a new button-1 press pulse is generated -> event_o[1] stays 1.
- Release after hold: raw[3] 1->0 with buttons_o[3]=1 -> release_o[3] pulses once, 6 edges after the change. press_o stays 0 and event_o[3] is unchanged.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants and per-channel payload type for the push-button front end.
//   BTN_NUM_DEF          default number of button channels
//   BTN_DEBOUNCE_CYCLES  default qualification time (10 ms at 100 MHz)
//   BTN_EVENT_ADDR       memory-map offset of the sticky event register (read / clear)
//   btn_chan_t           registered outputs of one debounce channel
package button_conditioner_pkg;

  localparam int unsigned BTN_NUM_DEF         = 4;
  localparam int unsigned BTN_DEBOUNCE_CYCLES = 1000000;
  localparam logic [31:0] BTN_EVENT_ADDR      = 32'h0000_0010;

  typedef struct packed {
    logic level;  // debounced stable level
    logic press;  // one-cycle pulse on 0->1
    logic rls;    // one-cycle pulse on 1->0
  } btn_chan_t;

endpackage : button_conditioner_pkg

// File: rtl/btn_debounce_bit.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level and
// press/release pulse generation.
//   clk, rst    clock, async active-low reset
//   raw_i       raw asynchronous pad input (1 = pressed)
//   chan_o      registered {level, press, rls}
//   press_c     value being loaded into chan_o.press this cycle (feeds the event register)
module btn_debounce_bit
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw_i,
  output btn_chan_t chan_o,
  output logic      press_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, rls_q, rls_c;

  // Two-flop synchronizer; only s2_q is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Qualification: the level flips on the DEBOUNCE_CYCLES-th consecutive
  // differing sample; any matching sample restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_c  = 1'b0;
    rls_c    = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        press_c  = s2_q;
        rls_c    = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Level, counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rls_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_c;
      rls_q    <= rls_c;
    end
  end

  assign chan_o = '{level: stable_q, press: press_q, rls: rls_q};

endmodule : btn_debounce_bit

// File: rtl/button_conditioner.sv
// Push-button front end: per-button debounce channels plus a sticky
// "pressed since last clear" event register cleared through a mask.
//   clk, rst        clock, async active-low reset
//   buttons_raw_i   raw asynchronous pad inputs (1 = pressed)
//   buttons_o       debounced levels
//   press_o         one-cycle pulse on debounced 0->1
//   release_o       one-cycle pulse on debounced 1->0
//   event_o         sticky press flags
//   event_clr_i     per-bit clear mask for event_o, sampled every cycle
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned BTN_NUM         = BTN_NUM_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_NUM-1:0] buttons_raw_i,
  output logic [BTN_NUM-1:0] buttons_o,
  output logic [BTN_NUM-1:0] press_o,
  output logic [BTN_NUM-1:0] release_o,
  output logic [BTN_NUM-1:0] event_o,
  input  logic [BTN_NUM-1:0] event_clr_i
);

  btn_chan_t          chan [BTN_NUM];
  logic [BTN_NUM-1:0] press_c;
  logic [BTN_NUM-1:0] event_q;

  // One independent debounce channel per button.
  for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
    btn_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (buttons_raw_i[i]),
      .chan_o  (chan[i]),
      .press_c (press_c[i])
    );
    assign buttons_o[i] = chan[i].level;
    assign press_o[i]   = chan[i].press;
    assign release_o[i] = chan[i].rls;
  end

  // Sticky events; a press in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_q <= '0;
    end else begin
      event_q <= (event_q & ~event_clr_i) | press_c;
    end
  end

  assign event_o = event_q;

endmodule : button_conditioner
